// File: rtl/lock_sequencer.sv
// lock_sequencer: one boat-lock cycle (ARRIVE -> FANDP -> WAIT -> EVACUATE).
// Keeps the per-phase elapsed-tick counts for the display and decodes the
// door/pump enables from the registered state.
module lock_sequencer #(
    parameter int CW         = 10,
    parameter int ARRIVE_MAX = 4,
    parameter int FANDP_MAX  = 7,
    parameter int EVAC_MAX   = 8
) (
    input  logic          Clock,
    input  logic          Reset,
    input  logic          tick,
    input  logic          pause,
    input  logic          arriveReq,
    input  logic          evacReq,
    output logic [CW-1:0] countArrive,
    output logic [CW-1:0] countFandP,
    output logic [CW-1:0] countEvacuate,
    output logic          outerDoor,
    output logic          innerDoor,
    output logic          pumpOn,
    output logic          busy,
    output logic [2:0]    state
);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_ARRIVE   = 3'd1,
        S_FANDP    = 3'd2,
        S_WAIT     = 3'd3,
        S_EVACUATE = 3'd4
    } state_t;

    localparam logic [CW-1:0] ARRIVE_LIM = CW'(ARRIVE_MAX);
    localparam logic [CW-1:0] FANDP_LIM  = CW'(FANDP_MAX);
    localparam logic [CW-1:0] EVAC_LIM   = CW'(EVAC_MAX);
    localparam logic [CW-1:0] ONE        = CW'(1);

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_arrive_q, cnt_arrive_d;
    logic [CW-1:0] cnt_fandp_q,  cnt_fandp_d;
    logic [CW-1:0] cnt_evac_q,   cnt_evac_d;
    logic          adv;

    // A paused tick is treated exactly like no tick at all.
    assign adv = tick & ~pause;

    // State and count registers; reset returns to IDLE with all counts cleared.
    always_ff @(posedge Clock) begin
        if (!Reset) begin
            state_q      <= S_IDLE;
            cnt_arrive_q <= '0;
            cnt_fandp_q  <= '0;
            cnt_evac_q   <= '0;
        end else begin
            state_q      <= state_d;
            cnt_arrive_q <= cnt_arrive_d;
            cnt_fandp_q  <= cnt_fandp_d;
            cnt_evac_q   <= cnt_evac_d;
        end
    end

    // Next state and counts: timed phases count to MAX, then hand over on the following adv.
    always_comb begin
        state_d      = state_q;
        cnt_arrive_d = cnt_arrive_q;
        cnt_fandp_d  = cnt_fandp_q;
        cnt_evac_d   = cnt_evac_q;
        case (state_q)
            S_IDLE: begin
                cnt_arrive_d = '0;
                cnt_fandp_d  = '0;
                cnt_evac_d   = '0;
                if (arriveReq) begin
                    state_d = S_ARRIVE;
                end
            end
            S_ARRIVE: begin
                if (adv) begin
                    if (cnt_arrive_q < ARRIVE_LIM) begin
                        cnt_arrive_d = cnt_arrive_q + ONE;
                    end else begin
                        state_d     = S_FANDP;
                        cnt_fandp_d = '0;
                    end
                end
            end
            S_FANDP: begin
                if (adv) begin
                    if (cnt_fandp_q < FANDP_LIM) begin
                        cnt_fandp_d = cnt_fandp_q + ONE;
                    end else begin
                        state_d = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                if (evacReq) begin
                    state_d    = S_EVACUATE;
                    cnt_evac_d = '0;
                end
            end
            S_EVACUATE: begin
                if (adv) begin
                    if (cnt_evac_q < EVAC_LIM) begin
                        cnt_evac_d = cnt_evac_q + ONE;
                    end else begin
                        // Cycle complete: the display returns to all zeros with IDLE.
                        state_d      = S_IDLE;
                        cnt_arrive_d = '0;
                        cnt_fandp_d  = '0;
                        cnt_evac_d   = '0;
                    end
                end
            end
            default: begin
                // Unreachable encodings recover to a clean IDLE.
                state_d      = S_IDLE;
                cnt_arrive_d = '0;
                cnt_fandp_d  = '0;
                cnt_evac_d   = '0;
            end
        endcase
    end

    // Output decode from the registered state, so doors and pump move with the state.
    always_comb begin
        outerDoor = 1'b0;
        innerDoor = 1'b0;
        pumpOn    = 1'b0;
        case (state_q)
            S_ARRIVE:   outerDoor = 1'b1;
            S_FANDP:    pumpOn    = 1'b1;
            S_WAIT:     innerDoor = 1'b1;
            S_EVACUATE: pumpOn    = 1'b1;
            default:    ;
        endcase
    end

    assign busy          = (state_q != S_IDLE);
    assign state         = state_q;
    assign countArrive   = cnt_arrive_q;
    assign countFandP    = cnt_fandp_q;
    assign countEvacuate = cnt_evac_q;

    // The two gates must never be open together.
    a_door_interlock: assert property (@(posedge Clock) !(innerDoor && outerDoor));

endmodule

// File: tb/tb_lock_sequencer.sv
// Scoreboard bench for lock_sequencer: a phase/count reference model predicts
// the outputs after each edge; a monitor compares them one cycle at a time.
module tb_lock_sequencer;

    localparam int CW = 10;
    localparam int MAXV [3] = '{4, 7, 8};

    logic          Clock = 1'b0;
    logic          Reset = 1'b0;
    logic          tick = 1'b0, pause = 1'b0, arriveReq = 1'b0, evacReq = 1'b0;
    logic [CW-1:0] countArrive, countFandP, countEvacuate;
    logic          outerDoor, innerDoor, pumpOn, busy;
    logic [2:0]    state;

    lock_sequencer #(.CW(CW), .ARRIVE_MAX(4), .FANDP_MAX(7), .EVAC_MAX(8)) dut (
        .Clock(Clock), .Reset(Reset), .tick(tick), .pause(pause),
        .arriveReq(arriveReq), .evacReq(evacReq),
        .countArrive(countArrive), .countFandP(countFandP),
        .countEvacuate(countEvacuate), .outerDoor(outerDoor),
        .innerDoor(innerDoor), .pumpOn(pumpOn), .busy(busy), .state(state)
    );

    always #5 Clock = ~Clock;

    typedef struct packed {
        logic [2:0]    st;
        logic [CW-1:0] ca;
        logic [CW-1:0] cf;
        logic [CW-1:0] ce;
        logic          outer;
        logic          inner;
        logic          pump;
        logic          bsy;
    } obs_t;

    obs_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;

    // Reference model: phase 0=idle,1=arrive,2=fill,3=wait,4=evacuate; cnt[k] belongs to
    // the k-th timed phase (arrive, fill, evacuate).
    int phase = 0;
    int cnt [3] = '{0, 0, 0};

    function automatic int timed_index(input int p);
        return (p == 1) ? 0 : (p == 2) ? 1 : 2;
    endfunction

    task automatic model_edge(input bit rst_n, input bit tk, input bit ps, input bit ar, input bit ev);
        int k;
        if (!rst_n) begin
            phase = 0;
            cnt = '{0, 0, 0};
        end else if (phase == 0) begin
            if (ar) phase = 1;
        end else if (phase == 3) begin
            if (ev) begin
                phase = 4;
                cnt[2] = 0;
            end
        end else if (tk && !ps) begin
            k = timed_index(phase);
            if (cnt[k] < MAXV[k]) begin
                cnt[k]++;
            end else if (phase == 4) begin
                phase = 0;
                cnt = '{0, 0, 0};
            end else begin
                phase++;
                if (phase == 2) cnt[1] = 0;
            end
        end
    endtask

    function automatic obs_t predict();
        obs_t o;
        o.st    = 3'(phase);
        o.ca    = CW'(cnt[0]);
        o.cf    = CW'(cnt[1]);
        o.ce    = CW'(cnt[2]);
        o.outer = (phase == 1);
        o.inner = (phase == 3);
        o.pump  = (phase == 2) || (phase == 4);
        o.bsy   = (phase != 0);
        return o;
    endfunction

    // One cycle of stimulus: drive at the falling edge, predict the post-edge outputs.
    task automatic step(input bit rst_n, input bit tk, input bit ps, input bit ar, input bit ev);
        @(negedge Clock);
        Reset = rst_n; tick = tk; pause = ps; arriveReq = ar; evacReq = ev;
        model_edge(rst_n, tk, ps, ar, ev);
        exp_q.push_back(predict());
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) step(1, 1, 0, 0, 0);
    endtask

    // Monitor: after every rising edge, compare the DUT with the oldest prediction.
    initial begin
        obs_t act, e;
        forever begin
            @(posedge Clock);
            #1;
            cyc++;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                act = '{state, countArrive, countFandP, countEvacuate, outerDoor, innerDoor, pumpOn, busy};
                checks++;
                if (act !== e) begin
                    errors++;
                    $display("FAIL cycle%0d: got st=%0d cA=%0d cF=%0d cE=%0d out=%b in=%b pump=%b busy=%b, expected st=%0d cA=%0d cF=%0d cE=%0d out=%b in=%b pump=%b busy=%b",
                             cyc, act.st, act.ca, act.cf, act.ce, act.outer, act.inner, act.pump, act.bsy,
                             e.st, e.ca, e.cf, e.ce, e.outer, e.inner, e.pump, e.bsy);
                end
            end
        end
    end

    initial begin
        // Reset state
        step(0, 0, 0, 0, 0);
        step(0, 1, 0, 1, 1);
        step(1, 0, 0, 0, 1);            // evacReq in IDLE: ignored
        step(1, 1, 0, 0, 1);
        // Arrive pulse, five ticks into FANDP, three more, then reset mid-cycle
        step(1, 0, 0, 1, 0);
        step(1, 0, 0, 0, 0);
        ticks(5);
        ticks(3);
        step(0, 0, 0, 0, 0);
        step(0, 1, 0, 0, 0);
        step(1, 0, 0, 0, 0);
        // Pause holds the arrive count
        step(1, 0, 0, 1, 0);
        ticks(2);
        for (int i = 0; i < 3; i++) step(1, 1, 1, 0, 0);
        ticks(1);
        ticks(2);
        // evacReq during FANDP is ignored
        for (int i = 0; i < 3; i++) step(1, 0, 0, 0, 1);
        ticks(8);
        // arriveReq and ticks in WAIT are ignored; then evacuate
        for (int i = 0; i < 4; i++) step(1, 1, 0, 1, 0);
        step(1, 0, 0, 0, 1);
        step(1, 0, 0, 0, 0);
        ticks(9);
        // Held arriveReq at end of a cycle restarts immediately
        step(1, 0, 0, 1, 0);
        ticks(5);
        ticks(8);
        step(1, 0, 0, 0, 1);
        for (int i = 0; i < 9; i++) step(1, 1, 0, 1, 0);
        step(1, 0, 0, 1, 0);
        step(1, 0, 0, 0, 0);
        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            step(($urandom_range(0, 199) != 0),
                 ($urandom_range(0, 1) == 1),
                 ($urandom_range(0, 4) == 0),
                 ($urandom_range(0, 3) == 0),
                 ($urandom_range(0, 3) == 0));
        end
        step(1, 0, 0, 0, 0);
        // Drain the scoreboard, bounded
        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge Clock);
        @(negedge Clock);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d predictions left, expected 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
